// File: rtl/nasti_lite_write_bridge_pkg.sv
// nasti_pkg: NASTI response/burst encodings, response merge and bridge states.
// Shared by the write bridge and its bus interface.
package nasti_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_RESP,
    S_B
  } state_e;

  // Worst response wins; EXOKAY folds into OKAY.
  function automatic logic [1:0] nasti_resp_merge(
    input logic [1:0] a,
    input logic [1:0] b
  );
    if (a == RESP_DECERR || b == RESP_DECERR)
      return RESP_DECERR;
    else if (a == RESP_SLVERR || b == RESP_SLVERR)
      return RESP_SLVERR;
    else
      return RESP_OKAY;
  endfunction

endpackage

// File: rtl/nasti_lite_write_bridge_if.sv
// Bus bundle for the NASTI->NASTI-Lite write bridge.
// slave: the bridge's view; master: the surrounding system's view.
interface nasti_lite_write_bridge_if #(
  parameter int ID_WIDTH   = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1
);

  logic [ID_WIDTH-1:0]     nasti_aw_id;
  logic [ADDR_WIDTH-1:0]   nasti_aw_addr;
  logic [7:0]              nasti_aw_len;
  logic [2:0]              nasti_aw_size;
  logic [1:0]              nasti_aw_burst;
  logic [2:0]              nasti_aw_prot;
  logic [USER_WIDTH-1:0]   nasti_aw_user;
  logic                    nasti_aw_lock;
  logic [3:0]              nasti_aw_cache;
  logic [3:0]              nasti_aw_qos;
  logic [3:0]              nasti_aw_region;
  logic                    nasti_aw_valid;
  logic                    nasti_aw_ready;

  logic [DATA_WIDTH-1:0]   nasti_w_data;
  logic [DATA_WIDTH/8-1:0] nasti_w_strb;
  logic                    nasti_w_last;
  logic [USER_WIDTH-1:0]   nasti_w_user;
  logic                    nasti_w_valid;
  logic                    nasti_w_ready;

  logic [ID_WIDTH-1:0]     nasti_b_id;
  logic [1:0]              nasti_b_resp;
  logic [USER_WIDTH-1:0]   nasti_b_user;
  logic                    nasti_b_valid;
  logic                    nasti_b_ready;

  logic [ADDR_WIDTH-1:0]   lite_aw_addr;
  logic [2:0]              lite_aw_prot;
  logic                    lite_aw_valid;
  logic                    lite_aw_ready;

  logic [DATA_WIDTH-1:0]   lite_w_data;
  logic [DATA_WIDTH/8-1:0] lite_w_strb;
  logic                    lite_w_valid;
  logic                    lite_w_ready;

  logic [1:0]              lite_b_resp;
  logic                    lite_b_valid;
  logic                    lite_b_ready;

  modport slave (
    input  nasti_aw_id, nasti_aw_addr, nasti_aw_len,
    input  nasti_aw_size, nasti_aw_burst, nasti_aw_prot,
    input  nasti_aw_user, nasti_aw_lock, nasti_aw_cache,
    input  nasti_aw_qos, nasti_aw_region, nasti_aw_valid,
    output nasti_aw_ready,
    input  nasti_w_data, nasti_w_strb, nasti_w_last,
    input  nasti_w_user, nasti_w_valid,
    output nasti_w_ready,
    output nasti_b_id, nasti_b_resp, nasti_b_user, nasti_b_valid,
    input  nasti_b_ready,
    output lite_aw_addr, lite_aw_prot, lite_aw_valid,
    input  lite_aw_ready,
    output lite_w_data, lite_w_strb, lite_w_valid,
    input  lite_w_ready,
    input  lite_b_resp, lite_b_valid,
    output lite_b_ready
  );

  modport master (
    output nasti_aw_id, nasti_aw_addr, nasti_aw_len,
    output nasti_aw_size, nasti_aw_burst, nasti_aw_prot,
    output nasti_aw_user, nasti_aw_lock, nasti_aw_cache,
    output nasti_aw_qos, nasti_aw_region, nasti_aw_valid,
    input  nasti_aw_ready,
    output nasti_w_data, nasti_w_strb, nasti_w_last,
    output nasti_w_user, nasti_w_valid,
    input  nasti_w_ready,
    input  nasti_b_id, nasti_b_resp, nasti_b_user, nasti_b_valid,
    output nasti_b_ready,
    input  lite_aw_addr, lite_aw_prot, lite_aw_valid,
    output lite_aw_ready,
    input  lite_w_data, lite_w_strb, lite_w_valid,
    output lite_w_ready,
    output lite_b_resp, lite_b_valid,
    input  lite_b_ready
  );

endinterface

// File: rtl/nasti_lite_write_bridge.sv
// Splits NASTI INCR write bursts into single-beat NASTI-Lite writes.
// Define NASTI_LITE_BRIDGE_CHECK_EN to trap illegal bursts and bad w_last.
module nasti_lite_write_bridge
  import nasti_pkg::*;
#(
  parameter int ID_WIDTH   = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1
) (
  input logic clk,
  input logic rstn,
  nasti_lite_write_bridge_if.slave bus
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH/8));

  state_e state, state_nxt;

  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [7:0]            cnt_q;
  logic [2:0]            size_q;
  logic [2:0]            prot_q;
  logic [USER_WIDTH-1:0] user_q;
  logic [1:0]            resp_q;
  logic                  aw_done;
  logic                  w_done;

  logic                  in_req;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  last_beat;
  logic [2:0]            size_in;
  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic                  unused_ok;

`ifdef NASTI_LITE_BRIDGE_CHECK_EN
  assign size_in = bus.nasti_aw_size;
`else
  assign size_in = (bus.nasti_aw_size > MAX_SIZE) ?
                   MAX_SIZE : bus.nasti_aw_size;
`endif

  assign in_req    = (state == S_REQ);
  assign aw_hs     = in_req && !aw_done && bus.lite_aw_ready;
  assign w_hs      = in_req && !w_done &&
                     bus.nasti_w_valid && bus.lite_w_ready;
  assign last_beat = (cnt_q == len_q);

  // Later beats snap to the size boundary, then advance one beat.
  assign step     = ADDR_WIDTH'(1) << size_q;
  assign addr_nxt = (addr_q & ~(step - ADDR_WIDTH'(1))) + step;

  assign bus.lite_aw_addr = addr_q;
  assign bus.lite_aw_prot = prot_q;
  assign bus.lite_w_data  = bus.nasti_w_data;
  assign bus.lite_w_strb  = bus.nasti_w_strb;
  assign bus.nasti_b_id   = id_q;
  assign bus.nasti_b_resp = resp_q;
  assign bus.nasti_b_user = user_q;

  assign unused_ok = ^{bus.nasti_aw_lock, bus.nasti_aw_cache,
                       bus.nasti_aw_qos, bus.nasti_aw_region,
                       bus.nasti_aw_burst, bus.nasti_w_last,
                       bus.nasti_w_user};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt          = state;
    bus.nasti_aw_ready = 1'b0;
    bus.lite_aw_valid  = 1'b0;
    bus.lite_w_valid   = 1'b0;
    bus.nasti_w_ready  = 1'b0;
    bus.lite_b_ready   = 1'b0;
    bus.nasti_b_valid  = 1'b0;
    unique case (state)
      S_IDLE: begin
        bus.nasti_aw_ready = 1'b1;
        if (bus.nasti_aw_valid) state_nxt = S_REQ;
      end
      S_REQ: begin
        bus.lite_aw_valid = !aw_done;
        bus.lite_w_valid  = bus.nasti_w_valid && !w_done;
        bus.nasti_w_ready = bus.lite_w_ready && !w_done;
        if ((aw_done || aw_hs) && (w_done || w_hs))
          state_nxt = S_RESP;
      end
      S_RESP: begin
        bus.lite_b_ready = 1'b1;
        if (bus.lite_b_valid)
          state_nxt = last_beat ? S_B : S_REQ;
      end
      S_B: begin
        bus.nasti_b_valid = 1'b1;
        if (bus.nasti_b_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      prot_q  <= '0;
      user_q  <= '0;
      resp_q  <= RESP_OKAY;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.nasti_aw_valid) begin
            id_q    <= bus.nasti_aw_id;
            addr_q  <= bus.nasti_aw_addr;
            len_q   <= bus.nasti_aw_len;
            size_q  <= size_in;
            prot_q  <= bus.nasti_aw_prot;
            user_q  <= bus.nasti_aw_user;
            cnt_q   <= '0;
            resp_q  <= RESP_OKAY;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
          end
        end
        S_REQ: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
        end
        S_RESP: begin
          if (bus.lite_b_valid) begin
            resp_q <= nasti_resp_merge(resp_q, bus.lite_b_resp);
            if (!last_beat) begin
              cnt_q   <= cnt_q + 8'd1;
              addr_q  <= addr_nxt;
              aw_done <= 1'b0;
              w_done  <= 1'b0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef NASTI_LITE_BRIDGE_CHECK_EN
  always_ff @(posedge clk) begin
    if (rstn && state == S_IDLE && bus.nasti_aw_valid) begin
      if (bus.nasti_aw_burst != BURST_INCR)
        $fatal(1, "nasti_lite_write_bridge: non-INCR burst");
      if (bus.nasti_aw_size > MAX_SIZE)
        $fatal(1, "nasti_lite_write_bridge: oversize beat");
    end
    if (rstn && w_hs && (bus.nasti_w_last != last_beat))
      $fatal(1, "nasti_lite_write_bridge: w_last mismatch");
  end
`endif

endmodule
